// File: rtl/nibble_seq.sv
// Nibble-serial ALU sequencer: drives an external 4-bit ALU one nibble per cycle.
// Optional signed-overflow flag enabled by defining NIBBLE_SEQ_OVF_EN.
module nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [4*NIBBLES-1:0]   opa,
    input  logic [4*NIBBLES-1:0]   opb,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry,
    output logic                   zero,
    output logic                   ovf,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_crin,
    input  logic [3:0]             alu_f,
    input  logic                   alu_crout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_MOVB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   res_q, res_d;
    logic           cy_q, cy_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;
`ifdef NIBBLE_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    logic arith;
    logic last;

    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign last  = (idx_q == IW'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`ifdef NIBBLE_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
`ifdef NIBBLE_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        cy_d     = cy_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
`ifdef NIBBLE_SEQ_OVF_EN
        ovf_d    = ovf_q;
`endif
        alu_a    = 4'd0;
        alu_b    = 4'd0;
        alu_s    = 4'd0;
        alu_m    = 1'b0;
        alu_crin = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    idx_d   = '0;
                    res_d   = '0;
                    cy_d    = 1'b0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
`ifdef NIBBLE_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a = opa_q[{idx_q, 2'b00} +: 4];
                alu_b = opb_q[{idx_q, 2'b00} +: 4];
                unique case (op_q)
                    OP_ADD:  begin alu_s = 4'h9; alu_m = 1'b0; end
                    OP_SUB:  begin alu_s = 4'h6; alu_m = 1'b0; end
                    OP_NOR:  begin alu_s = 4'h1; alu_m = 1'b1; end
                    default: begin alu_s = 4'hA; alu_m = 1'b1; end
                endcase
                // Nibble 0 seeds the chain: SUB is A + ~B + 1
                if (arith) begin
                    alu_crin = (idx_q == '0) ? (op_q == OP_SUB) : cy_q;
                end
                res_d[{idx_q, 2'b00} +: 4] = alu_f;
                cy_d  = alu_crout;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    idx_d   = '0;
                    carry_d = arith & alu_crout;
                    zero_d  = (res_d == '0);
`ifdef NIBBLE_SEQ_OVF_EN
                    if (op_q == OP_ADD) begin
                        ovf_d = (opa_q[W-1] == opb_q[W-1]) && (alu_f[3] != opa_q[W-1]);
                    end else if (op_q == OP_SUB) begin
                        ovf_d = (opa_q[W-1] != opb_q[W-1]) && (alu_f[3] != opa_q[W-1]);
                    end else begin
                        ovf_d = 1'b0;
                    end
`endif
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
`ifdef NIBBLE_SEQ_OVF_EN
    assign ovf    = ovf_q;
`else
    assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_seq.sv
// Self-checking bench for nibble_seq with a behavioural 4-bit ALU on the alu_* port.
// Expected values come from whole-word arithmetic on the operands.
module tb_nibble_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa, opb;
    logic        ready, done;
    logic [15:0] result;
    logic        carry, zero, ovf;
    logic [3:0]  alu_a, alu_b, alu_s, alu_f;
    logic        alu_m, alu_crin, alu_crout;
    logic [4:0]  alu_t;

    int passed = 0;
    int total  = 0;

`ifdef NIBBLE_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    nibble_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opa(opa), .opb(opb), .ready(ready), .done(done),
        .result(result), .carry(carry), .zero(zero), .ovf(ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_crin(alu_crin), .alu_f(alu_f), .alu_crout(alu_crout)
    );

    always #5 clk = ~clk;

    // External ALU: combinational response to the selected function
    always_comb begin
        alu_t     = 5'd0;
        alu_f     = 4'd0;
        alu_crout = 1'b0;
        if (alu_m) begin
            if (alu_s == 4'h1) alu_f = ~(alu_a | alu_b);
            else if (alu_s == 4'hA) alu_f = alu_b;
        end else begin
            if (alu_s == 4'h9)
                alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_crin};
            else if (alu_s == 4'h6)
                alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_crin};
            alu_f     = alu_t[3:0];
            alu_crout = alu_t[4];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Returns {ovf, zero, carry, result}
    function automatic logic [18:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        s = 17'd0; c = 1'b0; v = 1'b0;
        case (o)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0]; c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            2'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r = s[15:0]; c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            2'd2: r = ~(a | b);
            default: r = b;
        endcase
        return {v & OVF_ON, (r == 16'd0), c, r};
    endfunction

    int          lat;
    logic [15:0] aseq, bseq;
    logic [3:0]  s0;
    logic        m0, crin0;
    logic [13:0] alu_at_done;

    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit keep);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        @(negedge clk);
        if (keep) begin
            op = ~o; opa = ~a; opb = a ^ b;
        end else begin
            start = 1'b0;
        end
        lat = 0; aseq = 16'd0; bseq = 16'd0;
        s0 = 4'd0; m0 = 1'b0; crin0 = 1'b0;
        alu_at_done = '1;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 4) begin
                aseq = {alu_a, aseq[15:4]};
                bseq = {alu_b, bseq[15:4]};
            end
            if (c == 1) begin
                s0 = alu_s; m0 = alu_m; crin0 = alu_crin;
            end
            if (done) begin
                lat = c;
                alu_at_done = {alu_a, alu_b, alu_s, alu_m, alu_crin};
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input bit keep);
        logic [18:0] e;
        logic [3:0]  es;
        e  = model(o, a, b);
        es = (o == 2'd0) ? 4'h9 : (o == 2'd1) ? 4'h6 : (o == 2'd2) ? 4'h1 : 4'hA;
        do_op(o, a, b, keep);
        check({tag, ".lat"},    lat, 5);
        check({tag, ".result"}, result, e[15:0]);
        check({tag, ".carry"},  carry, e[16]);
        check({tag, ".zero"},   zero, e[17]);
        check({tag, ".ovf"},    ovf, e[18]);
        check({tag, ".aseq"},   aseq, a);
        check({tag, ".bseq"},   bseq, b);
        check({tag, ".s0"},     s0, es);
        check({tag, ".m0"},     m0, o[1]);
        check({tag, ".crin0"},  crin0, (o == 2'd1));
        check({tag, ".aluidle"}, alu_at_done, 14'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        logic [18:0] e;
        int          dseen;
        rst = 1'b1; start = 1'b0; op = 2'd0; opa = 16'd0; opb = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.ready",  ready, 1'b1);
        check("rst.done",   done, 1'b0);
        check("rst.result", result, 16'd0);
        check("rst.flags",  {carry, zero, ovf}, 3'd0);
        check("rst.alu",    {alu_a, alu_b, alu_s, alu_m, alu_crin}, 14'd0);

        run_and_check("add_00ff", 2'd0, 16'h00FF, 16'h0001, 1'b0);
        check("add_00ff.const", result, 16'h0100);
        check("add_00ff.aconst", aseq, 16'h00FF);
        run_and_check("sub_eq",   2'd1, 16'h1234, 16'h1234, 1'b0);
        check("sub_eq.zc", {zero, carry}, 2'b11);
        run_and_check("add_wrap", 2'd0, 16'hFFFF, 16'h0001, 1'b0);
        run_and_check("nor",      2'd2, 16'hF0F0, 16'h0F00, 1'b0);
        check("nor.const", result, 16'h000F);
        run_and_check("ovf_add",  2'd0, 16'h7FFF, 16'h0001, 1'b0);
        check("ovf_add.const", ovf, OVF_ON);
        run_and_check("ovf_sub",  2'd1, 16'h8000, 16'h0001, 1'b0);
        check("ovf_sub.const", {result, ovf}, {16'h7FFF, OVF_ON});
        run_and_check("movb",     2'd3, 16'h1357, 16'hBEEF, 1'b0);

        // start held high with different operands during RUN
        run_and_check("ignore", 2'd0, 16'h1111, 16'h2222, 1'b1);
        repeat (2) @(negedge clk);
        check("hold.result", result, 16'h3333);
        check("hold.ready",  ready, 1'b1);

        // reset during RUN at idx=2
        @(negedge clk);
        start = 1'b1; op = 2'd0; opa = 16'h1111; opb = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid.alu_a", alu_a, 4'h1);
        rst = 1'b1;
        #1;
        check("mid.ready",  ready, 1'b1);
        check("mid.done",   done, 1'b0);
        check("mid.result", result, 16'd0);
        check("mid.flags",  {carry, zero, ovf}, 3'd0);
        check("mid.alu",    {alu_a, alu_b, alu_s, alu_m, alu_crin}, 14'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("mid.nodone", dseen, 0);
        run_and_check("post_rst", 2'd1, 16'h0005, 16'h0007, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 5) == 0) rb = ra;
            if ($urandom_range(0, 5) == 0) ra = 16'hFFFF;
            run_and_check($sformatf("rnd%0d", i), ro, ra, rb, i[0]);
            e = model(ro, ra, rb);
            @(negedge clk);
            check($sformatf("rnd%0d.held", i), {result, carry, zero, ovf}, {e[15:0], e[16], e[17], e[18]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nibble_seq.md
NIBBLE_SEQ -- requirements
Module: nibble_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit nibbles per operand (operand width 4*NIBBLES, NIBBLES >= 2).
REQ-002 SHALL have ports, one clock, reset asynchronous and active-high:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  asynchronous, active-high reset
  start  input  1  request new operation; accepted only when ready=1
  op  input  2  00 ADD, 01 SUB, 10 NOR, 11 MOVB
  opa  input  4*NIBBLES  operand A
  opb  input  4*NIBBLES  operand B
  ready  output  1  high only in IDLE
  done  output  1  one-cycle pulse, result/flags valid
  result  output  4*NIBBLES  assembled result
  carry  output  1  final nibble carry-out
  zero  output  1  result == 0
  ovf  output  1  signed overflow (see Configuration)
  alu_a  output  4  A nibble to external 4-bit ALU
  alu_b  output  4  B nibble to external ALU
  alu_s  output  4  ALU function select
  alu_m  output  1  ALU mode (1 logic, 0 arithmetic)
  alu_crin  output  1  ALU carry-in
  alu_f  input  4  ALU result nibble (combinational response)
  alu_crout  input  1  ALU carry-out

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-004 IDLE: ready=1; start=1 on an edge latches op, opa, opb, clears nibble index idx=0, enters RUN; start when not IDLE SHALL be ignored.
REQ-005 RUN: each cycle drive alu_a=opa_r nibble idx, alu_b=opb_r nibble idx (nibble 0 = bits 3:0); on edge store alu_f into result nibble idx, cy_r<=alu_crout, idx<=idx+1.
REQ-006 RUN SHALL last exactly NIBBLES cycles; after idx=NIBBLES-1 go to DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-007 Encodings: ADD m=0 s=9; SUB m=0 s=6 (A + ~B + cin); NOR m=1 s=1; MOVB m=1 s=A.
REQ-008 alu_crin: nibble 0 ADD=0, SUB=1; nibble k>0 = cy_r; logic ops always 0.
REQ-009 carry = alu_crout of last nibble for ADD/SUB (SUB: 1 = no borrow); 0 for NOR/MOVB.
REQ-010 zero SHALL reflect final result; result, carry, zero, ovf held from DONE until next accepted start.
REQ-011 Outside RUN, alu_a, alu_b, alu_s, alu_m, alu_crin SHALL be 0.
REQ-012 Latency: start accepted at edge 0; done high during cycle NIBBLES+1.

Reset
REQ-013 rst=1 SHALL immediately force IDLE, idx=0, ready=1, done=0, result=0, carry=0, zero=0, ovf=0, all alu_* outputs 0, regardless of state, including mid-RUN.
REQ-014 After rst deasserts, first start SHALL be accepted normally; aborted operation leaves no effect.

Configuration
REQ-015 Macro NIBBLE_SEQ_OVF_EN defined: ovf = signed overflow; ADD: opa msb == opb msb and result msb != opa msb; SUB: opa msb != opb msb and result msb != opa msb; NOR/MOVB 0; updated with result.
REQ-016 Macro undefined: ovf port present, tied 0, no overflow logic.

Verification (NIBBLES=4, behavioural 4-bit ALU model on alu_* ports)
REQ-017 ADD 0x00FF+0x0001 -> result 0x0100, carry 0, zero 0, done in cycle 5 after start edge; alu_a sequence F,F,0,0.
REQ-018 SUB 0x1234-0x1234 -> result 0x0000, carry 1, zero 1; nibble 0 alu_crin=1, alu_s=6, alu_m=0.
REQ-019 ADD 0xFFFF+0x0001 -> result 0x0000, carry 1, zero 1; NOR 0xF0F0,0x0F00 -> 0x000F, carry 0.
REQ-020 rst pulse during RUN idx=2 -> all outputs reset at once, no done; start during RUN ignored (result unchanged).
REQ-021 With NIBBLE_SEQ_OVF_EN: ADD 0x7FFF+0x0001 -> 0x8000, ovf 1; SUB 0x8000-0x0001 -> 0x7FFF, ovf 1; without macro ovf 0 both.
